// File: rtl/alu_64b_if.sv
// Decode/ALU bus for alu_64b: instruction fields and register operands in,
// registered control flags and ALU result out.
interface alu_64b_if #(
  parameter int DATA_W = 64
);
  logic [5:0]        opcode;
  logic [8:0]        xo;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              reg_dst;
  logic              alu_src;
  logic              mem_to_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              jump;
  logic              sign_zero;
  logic [1:0]        alu_op;
  logic [3:0]        alu_ctl;
  logic [DATA_W-1:0] alu_result;
  logic              zero;
  logic              overflow;

  modport master (
    output opcode, xo, imm16, read_data1, read_data2,
    input  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
           branch, jump, sign_zero, alu_op, alu_ctl, alu_result, zero, overflow
  );

  modport slave (
    input  opcode, xo, imm16, read_data1, read_data2,
    output reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
           branch, jump, sign_zero, alu_op, alu_ctl, alu_result, zero, overflow
  );
endinterface

// File: rtl/alu_64b.sv
// Single-cycle instruction decode, operand mux and 64-bit ALU; every output
// is registered once so results appear the cycle after the inputs.
module alu_64b #(
  parameter int DATA_W = 64
) (
  input logic       clk,
  input logic       rst_n,
  alu_64b_if.slave  bus
);

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SUBF = 4'b0111;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CTL_NAND = 4'b1101;

  // Subtraction is x + ~y + 1, so passing the inverted operand covers all adds.
  function automatic logic addOverflow(input logic signed [DATA_W-1:0] x,
                                       input logic signed [DATA_W-1:0] y,
                                       input logic signed [DATA_W-1:0] s);
    return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
  endfunction

  logic                     regDst_p0, aluSrc_p0, memToReg_p0, regWrite_p0;
  logic                     memRead_p0, memWrite_p0, branch_p0, jump_p0, signZero_p0;
  logic [1:0]               aluOp_p0;
  logic [3:0]               aluCtl_p0;
  logic signed [DATA_W-1:0] opA_p0, opB_p0, immExt_p0, result_p0;
  logic                     overflow_p0;

  // Stage p0: decode, operand select and ALU
  always_comb begin
    regDst_p0   = 1'b0;
    aluSrc_p0   = 1'b0;
    memToReg_p0 = 1'b0;
    regWrite_p0 = 1'b0;
    memRead_p0  = 1'b0;
    memWrite_p0 = 1'b0;
    branch_p0   = 1'b0;
    jump_p0     = 1'b0;
    signZero_p0 = 1'b0;
    aluOp_p0    = 2'b00;
    case (bus.opcode)
      6'd31: begin regDst_p0 = 1'b1; regWrite_p0 = 1'b1; aluOp_p0 = 2'b10; end
      6'd14: begin aluSrc_p0 = 1'b1; regWrite_p0 = 1'b1; aluOp_p0 = 2'b11; end
      6'd28, 6'd24, 6'd26: begin
        aluSrc_p0   = 1'b1;
        regWrite_p0 = 1'b1;
        signZero_p0 = 1'b1;
        aluOp_p0    = 2'b11;
      end
      6'd32, 6'd58: begin
        aluSrc_p0   = 1'b1;
        memToReg_p0 = 1'b1;
        regWrite_p0 = 1'b1;
        memRead_p0  = 1'b1;
      end
      6'd36, 6'd62: begin aluSrc_p0 = 1'b1; memWrite_p0 = 1'b1; end
      6'd19:        begin branch_p0 = 1'b1; aluOp_p0 = 2'b01; end
      6'd18:        jump_p0 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    aluCtl_p0 = CTL_ADD;
    case (aluOp_p0)
      2'b01: aluCtl_p0 = CTL_SUB;
      2'b11: begin
        case (bus.opcode)
          6'd28:   aluCtl_p0 = CTL_AND;
          6'd24:   aluCtl_p0 = CTL_OR;
          6'd26:   aluCtl_p0 = CTL_XOR;
          default: aluCtl_p0 = CTL_ADD;
        endcase
      end
      2'b10: begin
        case (bus.xo)
          9'd40:   aluCtl_p0 = CTL_SUBF;
          9'd28:   aluCtl_p0 = CTL_AND;
          9'd444:  aluCtl_p0 = CTL_OR;
          9'd316:  aluCtl_p0 = CTL_XOR;
          9'd476:  aluCtl_p0 = CTL_NAND;
          9'd124:  aluCtl_p0 = CTL_NOR;
          default: aluCtl_p0 = CTL_ADD;
        endcase
      end
      default: aluCtl_p0 = CTL_ADD;
    endcase
  end

  always_comb begin
    immExt_p0 = signZero_p0 ? {{(DATA_W-16){1'b0}}, bus.imm16}
                            : {{(DATA_W-16){bus.imm16[15]}}, bus.imm16};
    opA_p0      = bus.read_data1;
    opB_p0      = aluSrc_p0 ? immExt_p0 : bus.read_data2;
    result_p0   = '0;
    overflow_p0 = 1'b0;
    case (aluCtl_p0)
      CTL_ADD: begin
        result_p0   = opA_p0 + opB_p0;
        overflow_p0 = addOverflow(opA_p0, opB_p0, result_p0);
      end
      CTL_SUB: begin
        result_p0   = opA_p0 - opB_p0;
        overflow_p0 = addOverflow(opA_p0, ~opB_p0, result_p0);
      end
      CTL_SUBF: begin
        result_p0   = opB_p0 - opA_p0;
        overflow_p0 = addOverflow(opB_p0, ~opA_p0, result_p0);
      end
      CTL_AND:  result_p0 = opA_p0 & opB_p0;
      CTL_OR:   result_p0 = opA_p0 | opB_p0;
      CTL_XOR:  result_p0 = opA_p0 ^ opB_p0;
      CTL_NAND: result_p0 = ~(opA_p0 & opB_p0);
      CTL_NOR:  result_p0 = ~(opA_p0 | opB_p0);
      default:  result_p0 = '0;
    endcase
  end

  // Stage p1: output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.reg_dst    <= 1'b0;
      bus.alu_src    <= 1'b0;
      bus.mem_to_reg <= 1'b0;
      bus.reg_write  <= 1'b0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.branch     <= 1'b0;
      bus.jump       <= 1'b0;
      bus.sign_zero  <= 1'b0;
      bus.alu_op     <= 2'b00;
      bus.alu_ctl    <= 4'b0000;
      bus.alu_result <= '0;
      bus.zero       <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.reg_dst    <= regDst_p0;
      bus.alu_src    <= aluSrc_p0;
      bus.mem_to_reg <= memToReg_p0;
      bus.reg_write  <= regWrite_p0;
      bus.mem_read   <= memRead_p0;
      bus.mem_write  <= memWrite_p0;
      bus.branch     <= branch_p0;
      bus.jump       <= jump_p0;
      bus.sign_zero  <= signZero_p0;
      bus.alu_op     <= aluOp_p0;
      bus.alu_ctl    <= aluCtl_p0;
      bus.alu_result <= result_p0;
      bus.zero       <= (result_p0 == '0);
      bus.overflow   <= overflow_p0;
    end
  end

endmodule

// File: tb/tb_alu_64b.sv
// Directed-vector bench for alu_64b: each step drives one instruction and
// checks every registered output one cycle later against hand-computed values.
module tb_alu_64b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nVec = 0;
  int   nErr = 0;

  alu_64b_if #(.DATA_W(64)) bus ();

  alu_64b #(.DATA_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Flag order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump sign_zero
  localparam logic [8:0] F_XO  = 9'b100100000;
  localparam logic [8:0] F_ADI = 9'b010100000;
  localparam logic [8:0] F_LOG = 9'b010100001;
  localparam logic [8:0] F_LD  = 9'b011110000;
  localparam logic [8:0] F_ST  = 9'b010001000;
  localparam logic [8:0] F_BC  = 9'b000000100;
  localparam logic [8:0] F_B   = 9'b000000010;
  localparam logic [8:0] F_NONE = 9'b000000000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic [5:0] op, input logic [8:0] x,
                       input logic [15:0] im, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    rst_n          = rn;
    bus.opcode     = op;
    bus.xo         = x;
    bus.imm16      = im;
    bus.read_data1 = a;
    bus.read_data2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [8:0] flags, input logic [1:0] op,
                          input logic [3:0] ctl, input logic [63:0] res,
                          input logic z, input logic ovf);
    logic [8:0] actFlags;
    actFlags = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.branch, bus.jump, bus.sign_zero};
    chk({tag, ".flags"},    64'(actFlags),     64'(flags));
    chk({tag, ".alu_op"},   64'(bus.alu_op),   64'(op));
    chk({tag, ".alu_ctl"},  64'(bus.alu_ctl),  64'(ctl));
    chk({tag, ".result"},   bus.alu_result,    res);
    chk({tag, ".zero"},     64'(bus.zero),     64'(z));
    chk({tag, ".overflow"}, 64'(bus.overflow), 64'(ovf));
  endtask

  initial begin
    bus.opcode = 6'd0; bus.xo = 9'd0; bus.imm16 = 16'd0;
    bus.read_data1 = 64'd0; bus.read_data2 = 64'd0;

    // Reset holds everything at zero even with a store in flight.
    drive(1'b0, 6'd62, 9'd0, 16'h0010, 64'h100, 64'h5);
    checkAll("reset_std", F_NONE, 2'b00, 4'b0000, 64'd0, 1'b0, 1'b0);
    // First cycle after release reflects the store.
    drive(1'b1, 6'd62, 9'd0, 16'h0010, 64'h100, 64'h5);
    checkAll("std", F_ST, 2'b00, 4'b0010, 64'h110, 1'b0, 1'b0);

    drive(1'b1, 6'd31, 9'd266, 16'h0, 64'd5, 64'd7);
    checkAll("add", F_XO, 2'b10, 4'b0010, 64'd12, 1'b0, 1'b0);
    drive(1'b1, 6'd14, 9'd0, 16'hFFFF, 64'd3, 64'd99);
    checkAll("addi_neg", F_ADI, 2'b11, 4'b0010, 64'd2, 1'b0, 1'b0);
    drive(1'b1, 6'd24, 9'd0, 16'h8000, 64'd0, 64'd99);
    checkAll("ori_zext", F_LOG, 2'b11, 4'b0001, 64'h0000_0000_0000_8000, 1'b0, 1'b0);
    drive(1'b1, 6'd19, 9'd0, 16'h0, 64'd9, 64'd9);
    checkAll("bc_eq", F_BC, 2'b01, 4'b0110, 64'd0, 1'b1, 1'b0);
    drive(1'b1, 6'd31, 9'd266, 16'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    checkAll("add_ovf", F_XO, 2'b10, 4'b0010, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    drive(1'b1, 6'd19, 9'd0, 16'h0, 64'h8000_0000_0000_0000, 64'd1);
    checkAll("sub_ovf", F_BC, 2'b01, 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    drive(1'b1, 6'd31, 9'd40, 16'h0, 64'd1, 64'h10);
    checkAll("subf", F_XO, 2'b10, 4'b0111, 64'hF, 1'b0, 1'b0);
    drive(1'b1, 6'd31, 9'd40, 16'h0, 64'd1, 64'h8000_0000_0000_0000);
    checkAll("subf_ovf", F_XO, 2'b10, 4'b0111, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    drive(1'b1, 6'd31, 9'd476, 16'h0, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00);
    checkAll("nand", F_XO, 2'b10, 4'b1101, 64'h00FF_FFFF_00FF_FFFF, 1'b0, 1'b0);
    drive(1'b1, 6'd31, 9'd124, 16'h0, 64'd0, 64'd0);
    checkAll("nor", F_XO, 2'b10, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    drive(1'b1, 6'd31, 9'd316, 16'h0, 64'h1234, 64'h1234);
    checkAll("xor_zero", F_XO, 2'b10, 4'b0011, 64'd0, 1'b1, 1'b0);
    drive(1'b1, 6'd31, 9'd444, 16'h0, 64'hF0F0, 64'h0F0F_0000_0000_0000);
    checkAll("or", F_XO, 2'b10, 4'b0001, 64'h0F0F_0000_0000_F0F0, 1'b0, 1'b0);
    drive(1'b1, 6'd31, 9'd28, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    checkAll("and_xo", F_XO, 2'b10, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    drive(1'b1, 6'd31, 9'd0, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    checkAll("xo_dflt", F_XO, 2'b10, 4'b0010, 64'd0, 1'b1, 1'b0);
    drive(1'b1, 6'd28, 9'd0, 16'h00F0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    checkAll("andi", F_LOG, 2'b11, 4'b0000, 64'hF0, 1'b0, 1'b0);
    drive(1'b1, 6'd26, 9'd0, 16'hFFFF, 64'd0, 64'd0);
    checkAll("xori_zext", F_LOG, 2'b11, 4'b0011, 64'hFFFF, 1'b0, 1'b0);
    drive(1'b1, 6'd32, 9'd0, 16'hFFF8, 64'h100, 64'd7);
    checkAll("lwz", F_LD, 2'b00, 4'b0010, 64'hF8, 1'b0, 1'b0);
    drive(1'b1, 6'd58, 9'd0, 16'h0008, 64'h200, 64'd7);
    checkAll("ld", F_LD, 2'b00, 4'b0010, 64'h208, 1'b0, 1'b0);
    drive(1'b1, 6'd36, 9'd0, 16'h0004, 64'h40, 64'd7);
    checkAll("stw", F_ST, 2'b00, 4'b0010, 64'h44, 1'b0, 1'b0);
    drive(1'b1, 6'd18, 9'd0, 16'h0, 64'd4, 64'd6);
    checkAll("b", F_B, 2'b00, 4'b0010, 64'd10, 1'b0, 1'b0);
    drive(1'b1, 6'd5, 9'd266, 16'hFFFF, 64'd1, 64'd2);
    checkAll("unknown", F_NONE, 2'b00, 4'b0010, 64'd3, 1'b0, 1'b0);
    // Mid-stream reset overrides a live overflowing add.
    drive(1'b0, 6'd31, 9'd266, 16'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    checkAll("reset_mid", F_NONE, 2'b00, 4'b0000, 64'd0, 1'b0, 1'b0);
    drive(1'b1, 6'd19, 9'd0, 16'h0, 64'd10, 64'd3);
    checkAll("bc_ne", F_BC, 2'b01, 4'b0110, 64'd7, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
